adder_share_arbiter: RTL

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

---
 rtl/adder_share_arbiter_pkg.sv | 13 +
 rtl/adder_share_arbiter_adder.sv | 21 ++
 rtl/adder_share_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the adder-sharing arbiter:
// FSM state encoding and the adder result width.
package adder_share_arbiter_pkg;

  localparam int SUM_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// 8-bit approximate adder: the three LSBs are ORed (carry-in folded
// into bit 0); bit 2's AND generates the carry into the exact upper part.
module LSB_Three_AproximateORAdder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [8:0] S
);

  logic [2:0] lo;
  logic [5:0] hi;
  logic       lo_carry;

  always_comb begin
    lo       = (A[2:0] | B[2:0]) | {2'b00, Cin};
    lo_carry = A[2] & B[2];
    hi       = {1'b0, A[7:3]} + {1'b0, B[7:3]} + {5'b0, lo_carry};
    S        = {hi, lo};
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter letting N_REQ requesters time-share one
// approximate adder; one result in flight, held until handed off.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_A,
  input  logic [8*N_REQ-1:0] req_B,
  input  logic [N_REQ-1:0]   req_Cin,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_id,
  output logic [SUM_W-1:0]   rsp_S,
  output logic [CNT_W-1:0]   ops_done
);

  state_t state, state_next;

  logic [2:0]       last_grant;
  logic [2:0]       win_idx;
  logic             win_found;
  logic             window;
  logic             accept;
  logic [7:0]       sel_a, sel_b;
  logic             sel_cin;
  logic [7:0]       op_a, op_b;
  logic             op_cin;
  logic [2:0]       op_id;
  logic [SUM_W-1:0] sum;

  // Search starts just after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && req_valid[i] &&
            i == (int'(last_grant) + k) % N_REQ) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        sel_a   = req_A[8*i +: 8];
        sel_b   = req_B[8*i +: 8];
        sel_cin = req_Cin[i];
      end
    end
  end

  assign window = !rst &&
                  (state == IDLE || (state == RESP && rsp_ready));
  assign accept = window && win_found;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = accept ? EXEC : IDLE;
      EXEC:    state_next = RESP;
      RESP: begin
        if (rsp_ready) state_next = accept ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && (win_idx == 3'(i));
    end
    rsp_valid = (state == RESP);
  end

  LSB_Three_AproximateORAdder u_adder (
    .A   (op_a),
    .B   (op_b),
    .Cin (op_cin),
    .S   (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 3'(N_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_id      <= '0;
      rsp_S      <= '0;
      rsp_id     <= '0;
      ops_done   <= '0;
    end else begin
      if (accept) begin
        op_a       <= sel_a;
        op_b       <= sel_b;
        op_cin     <= sel_cin;
        op_id      <= win_idx;
        last_grant <= win_idx;
      end
      if (state == EXEC) begin
        rsp_S  <= sum;
        rsp_id <= op_id;
      end
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 1'b1;
    end
  end

endmodule
